// File: rtl/gf2m8_pkg.sv
// Shared GF(2^8) definitions for the RS decoder: field polynomial, element type
// and the reference product used by KES, Chien and Forney datapaths.
package gf2m8_pkg;

    typedef logic [7:0] gf8_t;

    // Low byte of the field polynomial; x^8 is implied (0x11D).
    localparam gf8_t GF_POLY = 8'h1D;

    // Carry-less multiply followed by top-down reduction. XOR/AND only, so
    // constant operands fold cleanly and no X can be manufactured internally.
    function automatic gf8_t gf8_mul(gf8_t a, gf8_t b, gf8_t poly = GF_POLY);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (a[i]) begin
                p = p ^ (15'(b) << i);
            end
        end
        for (int k = 14; k >= 8; k--) begin
            if (p[k]) begin
                p = p ^ (15'({1'b1, poly}) << (k - 8));
            end
        end
        return p[7:0];
    endfunction

endpackage

// File: rtl/gf2m8_mul_gated_if.sv
// Operand/result bundle of the gated GF(2^8) multiplier.
interface gf2m8_mul_gated_if;
    import gf2m8_pkg::*;

    logic ena;
    gf8_t x;
    gf8_t y;
    gf8_t z;
    gf8_t z_q;

    modport master (output ena, output x, output y, input z, input z_q);
    modport slave  (input ena, input x, input y, output z, output z_q);

endinterface

// File: rtl/gf2m8_cg_cell.sv
// Latch + AND clock gate; swappable for a library ICG cell at synthesis.
module gf2m8_cg_cell (
    input  logic clk,
    input  logic rstn,
    input  logic ena,
    output logic gclk
);

    logic en_l;

    // Transparent only while clk is low, so enable edges during the high
    // phase cannot reach the AND gate and cannot produce runt pulses.
    always_latch begin
        if (!rstn) begin
            en_l = 1'b0;
        end else if (!clk) begin
            en_l = ena;
        end
    end

    assign gclk = clk & en_l;

endmodule

// File: rtl/gf2m8_mul_gated.sv
// GF(2^8) combinational multiplier with its product registered on a gated clock.
module gf2m8_mul_gated
    import gf2m8_pkg::*;
#(
    parameter gf8_t POLY = GF_POLY
) (
    input  logic               clk,
    input  logic               rstn,
    output logic               gclk,
    gf2m8_mul_gated_if.slave   bus
);

    gf8_t z_next;
    gf8_t z_q_reg;

    assign z_next = gf8_mul(bus.x, bus.y, POLY);
    assign bus.z  = z_next;

    gf2m8_cg_cell u_cg (
        .clk  (clk),
        .rstn (rstn),
        .ena  (bus.ena),
        .gclk (gclk)
    );

    // Holds while the clock is gated off; reset clears it independently of gclk.
    always_ff @(posedge gclk or negedge rstn) begin
        if (!rstn) begin
            z_q_reg <= 8'h00;
        end else begin
            z_q_reg <= z_next;
        end
    end

    assign bus.z_q = z_q_reg;

endmodule

// File: tb/tb_gf2m8_mul_gated.sv
// Directed bench for the gated GF(2^8) multiplier: products, clock gating, reset.
module tb_gf2m8_mul_gated;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic gclk;

    gf2m8_mul_gated_if bus_if ();

    gf2m8_mul_gated dut (
        .clk  (clk),
        .rstn (rstn),
        .gclk (gclk),
        .bus  (bus_if)
    );

    always #5 clk = ~clk;

    int gclk_pulses = 0;
    always @(posedge gclk) gclk_pulses <= gclk_pulses + 1;

    int n_checks = 0;
    int n_pass   = 0;

    // Shift-and-xtime multiply, deliberately a different formulation from the RTL.
    function automatic logic [7:0] ref_mul(logic [7:0] a, logic [7:0] b);
        logic [7:0] r;
        logic [7:0] aa;
        r  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1D) : (aa << 1);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_xy(input logic [7:0] a, input logic [7:0] b);
        bus_if.x = a;
        bus_if.y = b;
    endtask

    int p0;
    logic [7:0] vx [5] = '{8'h01, 8'h00, 8'h02, 8'h03, 8'h02};
    logic [7:0] vy [5] = '{8'hA7, 8'h5A, 8'h80, 8'h03, 8'h02};
    logic [7:0] vz [5] = '{8'hA7, 8'h00, 8'h1D, 8'h05, 8'h04};

    initial begin
        bus_if.ena = 1'b1;
        set_xy(8'h00, 8'h00);

        // Reset held with ena=1 and clk running; z still follows the inputs.
        p0 = gclk_pulses;
        repeat (3) @(posedge clk);
        #1;
        check("rst_gclk", gclk, 1'b0);
        check("rst_zq", bus_if.z_q, 8'h00);
        check("rst_pulses", gclk_pulses - p0, 0);
        $display("step reset: gclk=%b z_q=%h", gclk, bus_if.z_q);

        set_xy(8'h02, 8'h80); #1; check("mul_02_80", bus_if.z, 8'h1D);
        set_xy(8'h04, 8'h80); #1; check("mul_04_80", bus_if.z, 8'h3A);
        set_xy(8'h80, 8'h80); #1; check("mul_80_80", bus_if.z, 8'h13);
        set_xy(8'h00, 8'h5A); #1; check("mul_zero", bus_if.z, 8'h00);
        set_xy(8'h01, 8'hA7); #1; check("mul_ident", bus_if.z, 8'hA7);
        $display("step vectors in reset: z=%h", bus_if.z);

        // Release in a high phase: no gclk until a low phase has passed.
        set_xy(8'h02, 8'h80);
        @(posedge clk); #2;
        rstn = 1'b1;
        p0 = gclk_pulses;
        #1;
        check("rel_high_gclk", gclk, 1'b0);
        check("rel_high_zq", bus_if.z_q, 8'h00);
        @(posedge clk); #1;
        check("first_gclk", gclk, 1'b1);
        check("first_zq", bus_if.z_q, 8'h1D);
        check("first_pulses", gclk_pulses - p0, 1);
        $display("step release: gclk=%b z_q=%h", gclk, bus_if.z_q);

        // Enable pulsed only inside a high phase must not produce a pulse.
        @(negedge clk);
        bus_if.ena = 1'b0;
        set_xy(8'h04, 8'h80);
        p0 = gclk_pulses;
        @(posedge clk); #1;
        bus_if.ena = 1'b1;
        #2;
        bus_if.ena = 1'b0;
        @(posedge clk); #1;
        check("hi_pulse_gclk", gclk, 1'b0);
        check("hi_pulse_cnt", gclk_pulses - p0, 0);
        check("hi_pulse_zq", bus_if.z_q, 8'h1D);
        $display("step ena in high phase: pulses=%0d z_q=%h", gclk_pulses - p0, bus_if.z_q);

        // Enable across one full low phase: exactly one pulse.
        @(negedge clk);
        bus_if.ena = 1'b1;
        @(posedge clk); #1;
        check("one_pulse_gclk", gclk, 1'b1);
        bus_if.ena = 1'b0;
        @(posedge clk); #1;
        check("one_pulse_cnt", gclk_pulses - p0, 1);
        check("one_pulse_zq", bus_if.z_q, 8'h3A);
        check("one_pulse_off", gclk, 1'b0);
        $display("step single low-phase enable: pulses=%0d z_q=%h", gclk_pulses - p0, bus_if.z_q);

        // Gated for five cycles while operands change: z tracks, z_q frozen.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            set_xy(vx[i], vy[i]);
            #1;
            check("gated_z", bus_if.z, vz[i]);
            @(posedge clk); #1;
            check("gated_zq", bus_if.z_q, 8'h3A);
            $display("step gated %0d: x=%h y=%h z=%h z_q=%h", i, bus_if.x, bus_if.y, bus_if.z, bus_if.z_q);
        end
        @(negedge clk);
        bus_if.ena = 1'b1;
        @(posedge clk); #1;
        check("reenable_zq", bus_if.z_q, 8'h04);

        // Held enable: gclk follows clk.
        @(negedge clk); #1;
        check("follow_low", gclk, 1'b0);
        set_xy(8'h80, 8'h80);
        @(posedge clk); #1;
        check("follow_high", gclk, 1'b1);
        check("follow_zq", bus_if.z_q, 8'h13);
        $display("step ena held: z_q=%h", bus_if.z_q);

        // Reset mid-burst in a high phase.
        @(negedge clk);
        set_xy(8'h02, 8'h80);
        @(posedge clk); #2;
        rstn = 1'b0;
        #1;
        check("mid_rst_gclk", gclk, 1'b0);
        check("mid_rst_zq", bus_if.z_q, 8'h00);
        @(negedge clk); #1;
        rstn = 1'b1;
        #1;
        check("mid_rel_zq", bus_if.z_q, 8'h00);
        @(posedge clk); #1;
        check("mid_rel_gclk", gclk, 1'b1);
        check("mid_rel_zq1", bus_if.z_q, 8'h1D);
        $display("step mid-burst reset: z_q=%h", bus_if.z_q);

        // Exhaustive sweep with the clock gated off; both operand orders.
        @(negedge clk);
        bus_if.ena = 1'b0;
        @(posedge clk); #1;
        p0 = gclk_pulses;
        for (int i = 0; i < 256; i++) begin
            for (int j = 0; j < 256; j++) begin
                set_xy(8'(i), 8'(j)); #1;
                check("sweep_mul", bus_if.z, ref_mul(8'(i), 8'(j)));
                set_xy(8'(j), 8'(i)); #1;
                check("sweep_comm", bus_if.z, ref_mul(8'(i), 8'(j)));
            end
            $display("step sweep x=%h done", 8'(i));
        end
        check("sweep_pulses", gclk_pulses - p0, 0);
        check("sweep_zq", bus_if.z_q, 8'h1D);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
